logic_gate_pipe: RTL and testbench
==================================

# logic_gate_pipe

- Parametrised, pipelined bitwise logic unit; successor to the single-bit 2-input gate cells in `basicgates`.
- Performs one of eight opcode-selected logic operations on two WIDTH-bit operands.
- Carries results through STAGES registered pipeline stages under a valid/ready handshake.
- Reports a zero flag, an illegal-opcode flag and a running transfer count; used as the shared logic datapath element.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 1–64.
- `STAGES`, default 2: number of pipeline register stages; legal range 1–4.
- `clk  in  1`: single clock; all state updates on its rising edge.
- `rst_n  in  1`: reset, synchronous, active-low.
- `in_valid  in  1`: operand set is present on `a`, `b`, `op`.
- `in_ready  out  1`: block accepts the operand set this cycle.
- `a  in  WIDTH`: operand A.
- `b  in  WIDTH`: operand B.
- `op  in  3`: opcode: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 RAND, 7 RXOR.
- `out_valid  out  1`: result is present.
- `out_ready  in  1`: downstream accepts the result.
- `y  out  WIDTH`: result.
- `y_zero  out  1`: y == 0, aligned with `y`.
- `err  out  1`: illegal opcode for this build, aligned with `y`.
- `tx_count  out  16`: number of completed output transfers; wraps.

## Operation
- **Compute:** result is computed combinationally from `a`, `b`, `op` at the input; the pipeline registers data, `y_zero`, `err` and valid only.
- **Opcodes 0–5:** bitwise across all WIDTH bits; NAND/NOR/XNOR are bitwise inversions of AND/OR/XOR.
- **Opcodes 6–7:** reduction opcodes, see Configuration; `b` is ignored.
- **Accept:** an input is accepted when `in_valid && in_ready`. An output is transferred when `out_valid && out_ready`.
- **Stage ready:** stage k may load when its valid is 0 or stage k+1 is loading (the last stage uses `out_ready`). `in_ready` equals stage-1 ready and is combinational on `out_ready`.
- **Bubbles:** a stage whose predecessor is empty while it advances loads valid=0.
- **Ordering:** results leave in acceptance order. No drop, no duplication.
- **Capacity:** the pipeline holds at most STAGES items.
- **tx_count:** increments by 1 per output transfer; 0xFFFF wraps to 0x0000.
- **Simultaneous events:**
  - A full pipeline with `out_ready=1` accepts a new input in the same cycle.
  - With `out_ready=0`, the full pipeline holds all data stable and `in_ready=0`.
- **Reset:**
  - `rst_n=0` at a rising edge clears all stage valids, data, `y_zero`, `err` and `tx_count` to 0.
  - In-flight items are discarded.
  - `in_ready` reads 1 in the first cycle after reset release.

## Timing
- **Reset values:** `out_valid=0`, `y=0`, `y_zero=0`, `err=0`, `tx_count=0`. `in_ready` is 1 whenever reset is deasserted and stage 1 is empty.
- **Latency:** an item accepted at edge N presents `out_valid=1` after edge N+STAGES-1, visible in cycle N+STAGES-1 → N+STAGES, when the path is unstalled. For STAGES=1, the result is visible the cycle after acceptance.
- **Throughput:** one result per cycle when `out_ready` is held at 1.
- **Stability:** `y`, `y_zero` and `err` are stable while `out_valid=1` and `out_ready=0`.
- **tx_count timing:** updates on the edge of the transfer and is visible the following cycle.

## Configuration
- **`LOGIC_GATE_PIPE_REDUCE_EN` defined:**
  - op 6: `y = {WIDTH-1 zeros, &a}`.
  - op 7: `y = {WIDTH-1 zeros, ^a}`.
  - `err=0` for all opcodes.
- **Macro undefined:**
  - Reduction logic is not built.
  - op 6/7 produce `y=0`, `y_zero=1`, `err=1`.
  - The item still flows through the pipeline and counts toward `tx_count`.

## Test plan
- **Bitwise ops** (WIDTH=8, STAGES=2, `out_ready=1`): a=0xF0, b=0x3C issued back-to-back with op 0,1,2,3,4,5 → y=0x30, 0xFC, 0xCC, 0xCF, 0x03, 0x33 in order, each 2 cycles after acceptance, `err=0`.
- **Zero flag:** a=0xAA, b=0x55, op 0 → y=0x00, `y_zero=1`; op 1 → y=0xFF, `y_zero=0`.
- **Backpressure:** `in_valid=1` continuously with incrementing a=0x01,0x02,… (b=0xFF, op 0), `out_ready=0` for 6 cycles:
  - exactly 2 items accepted, then `in_ready=0`;
  - `y` holds 0x01;
  - after `out_ready=1`, outputs are 0x01, 0x02, 0x03… with no gaps or repeats.
- **Reduction:** a=0xFF, op 6 → y=0x01, `err=0` with the macro defined; y=0x00, `err=1`, `y_zero=1` without it. a=0x07, op 7 → y=0x01 with the macro.
- **Counter wrap:** 65537 output transfers → `tx_count=0x0001`.
- **Reset mid-operation:** 2 items in flight, `rst_n=0` for one edge → next cycle `out_valid=0`, `tx_count=0`, `in_ready=1`; the items never appear at the output.

Source files
------------

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: pipelined bitwise logic unit with a valid/ready handshake.
// The result is formed combinationally at the input. STAGES register stages
// then carry the data, the zero flag, the error flag and the valid bit.
// Optional feature macro: LOGIC_GATE_PIPE_REDUCE_EN builds the reduction
// opcodes 6 (&a) and 7 (^a). When the macro is not defined, opcodes 6 and 7
// are flagged as illegal and produce y=0 and err=1.
module logic_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             err,
  output logic [15:0]      tx_count
);

  localparam int L = STAGES - 1;

  logic [WIDTH-1:0]              res;
  logic                          res_err;
  logic [STAGES-1:0]             rdy;
  logic [STAGES-1:0]             vld_q, vld_d;
  logic [STAGES-1:0]             z_q, z_d;
  logic [STAGES-1:0]             e_q, e_d;
  logic [STAGES-1:0][WIDTH-1:0]  y_q, y_d;
  logic [15:0]                   tx_q, tx_d;

  // Opcode decode and result formation on the incoming operands.
  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (op)
      3'd0: res = a & b;
      3'd1: res = a | b;
      3'd2: res = a ^ b;
      3'd3: res = ~(a & b);
      3'd4: res = ~(a | b);
      3'd5: res = ~(a ^ b);
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
      3'd6: res[0] = &a;
      3'd7: res[0] = ^a;
`else
      3'd6: res_err = 1'b1;
      3'd7: res_err = 1'b1;
`endif
      default: res = '0;
    endcase
  end

  // A stage may load when it, or any stage after it, has an empty slot, or
  // when the output is being drained. This is the flattened ready chain.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      rdy[k] = out_ready;
      for (int j = k; j < STAGES; j++)
        if (!vld_q[j]) rdy[k] = 1'b1;
    end
  end

  // Next-state logic: each ready stage takes its predecessor's contents.
  // An empty predecessor passes a bubble through.
  always_comb begin
    vld_d = vld_q;
    y_d   = y_q;
    z_d   = z_q;
    e_d   = e_q;
    if (rdy[0]) begin
      vld_d[0] = in_valid;
      y_d[0]   = res;
      z_d[0]   = (res == '0);
      e_d[0]   = res_err;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (rdy[k]) begin
        vld_d[k] = vld_q[k-1];
        y_d[k]   = y_q[k-1];
        z_d[k]   = z_q[k-1];
        e_d[k]   = e_q[k-1];
      end
    end
    tx_d = tx_q + ((vld_q[L] && out_ready) ? 16'd1 : 16'd0);
  end

  // Pipeline and transfer-count registers. Reset discards in-flight items.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      e_q   <= '0;
      tx_q  <= '0;
    end else begin
      vld_q <= vld_d;
      y_q   <= y_d;
      z_q   <= z_d;
      e_q   <= e_d;
      tx_q  <= tx_d;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[L];
  assign y         = y_q[L];
  assign y_zero    = z_q[L];
  assign err       = e_q[L];
  assign tx_count  = tx_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe (WIDTH=8, STAGES=2).
// The scoreboard learns each accepted operand set and checks every output
// transfer against its own reference model.
module tb_logic_gate_pipe;
  localparam int W = 8;
  localparam int S = 2;

  typedef logic [W+1:0] res_t;  // {y, y_zero, err}

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         in_ready, out_valid, y_zero, err;
  logic [W-1:0] y;
  logic [15:0]  tx_count;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          lat_chk = 1'b0;
  bit          rec = 1'b1;
  logic [15:0] tx_exp = '0;
  res_t        sb_q[$];
  int          acc_q[$];
  res_t        obs_q[$];

  logic_gate_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_zero(y_zero), .err(err), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [2:0] mop);
    logic [W-1:0] r;
    logic         e;
    r = '0;
    e = 1'b0;
    case (mop)
      3'd0: r = ma & mb;
      3'd1: r = ma | mb;
      3'd2: r = ma ^ mb;
      3'd3: r = ~(ma & mb);
      3'd4: r = ~(ma | mb);
      3'd5: r = ~(ma ^ mb);
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
      3'd6: r[0] = &ma;
      3'd7: r[0] = ^ma;
`else
      default: e = 1'b1;
`endif
    endcase
    return {r, (r == '0), e};
  endfunction

  // Scoreboard: pop and check on output transfer, push on input acceptance.
  always @(negedge clk) begin
    res_t exp_r;
    int   ac;
    if (!rst_n) begin
      sb_q.delete();
      acc_q.delete();
      tx_exp = '0;
    end else begin
      n_chk++;
      if (tx_count !== tx_exp) begin
        n_fail++;
        $display("FAIL tx_count_track: got %h expected %h", tx_count, tx_exp);
      end
      if (out_valid && out_ready) begin
        if (rec) obs_q.push_back({y, y_zero, err});
        n_chk++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got y=%h with empty scoreboard", y);
        end else begin
          exp_r = sb_q.pop_front();
          ac = acc_q.pop_front();
          if ({y, y_zero, err} !== exp_r) begin
            n_fail++;
            $display("FAIL sb_result: got %h expected %h", {y, y_zero, err}, exp_r);
          end
          if (lat_chk) begin
            n_chk++;
            if (cyc - ac != S) begin
              n_fail++;
              $display("FAIL latency: got %0d expected %0d", cyc - ac, S);
            end
          end
        end
        tx_exp = tx_exp + 16'd1;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(a, b, op));
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sb2, input logic [2:0] sop);
    bit ok;
    ok = 1'b0;
    a = sa; b = sb2; op = sop; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (sb_q.size() == 0) break;
    end
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_chk++; if (y !== 8'h00) begin n_fail++; $display("FAIL rst_y: got %h expected 00", y); end
    n_chk++; if (y_zero !== 1'b0) begin n_fail++; $display("FAIL rst_y_zero: got %b expected 0", y_zero); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err); end
    n_chk++; if (tx_count !== 16'h0000) begin n_fail++; $display("FAIL rst_tx: got %h expected 0000", tx_count); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_bitwise();
    logic [W-1:0] ev[6];
    res_t r;
    ev = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33};
    out_ready = 1'b1;
    lat_chk = 1'b1;
    obs_q.delete();
    for (int i = 0; i < 6; i++) send(8'hF0, 8'h3C, 3'(i));
    drain();
    lat_chk = 1'b0;
    n_chk++;
    if (obs_q.size() != 6) begin
      n_fail++;
      $display("FAIL bitwise_count: got %0d expected 6", obs_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        r = obs_q[i];
        n_chk++;
        if (r[W+1:2] !== ev[i] || r[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL bitwise_op%0d: got y=%h err=%b expected y=%h err=0", i, r[W+1:2], r[0], ev[i]);
        end
      end
    end
  endtask

  task automatic test_zero();
    res_t r;
    out_ready = 1'b1;
    obs_q.delete();
    send(8'hAA, 8'h55, 3'd0);
    send(8'hAA, 8'h55, 3'd1);
    drain();
    n_chk++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL zero_count: got %0d expected 2", obs_q.size());
    end else begin
      r = obs_q[0];
      n_chk++;
      if (r !== {8'h00, 1'b1, 1'b0}) begin n_fail++; $display("FAIL zero_and: got %h expected %h", r, {8'h00, 1'b1, 1'b0}); end
      r = obs_q[1];
      n_chk++;
      if (r !== {8'hFF, 1'b0, 1'b0}) begin n_fail++; $display("FAIL zero_or: got %h expected %h", r, {8'hFF, 1'b0, 1'b0}); end
    end
  endtask

  task automatic test_backpressure();
    int nxt, acc, guard;
    res_t r;
    out_ready = 1'b0;
    obs_q.delete();
    nxt = 1; acc = 0;
    b = 8'hFF; op = 3'd0; in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      a = W'(nxt);
      @(negedge clk);
      if (in_ready) begin acc++; nxt++; end
      if (c >= 2) begin
        n_chk++;
        if (y !== 8'h01 || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_hold: got y=%h vld=%b expected y=01 vld=1", y, out_valid);
        end
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (acc != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", acc); end
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    guard = 0;
    while (nxt <= 10 && guard < 100) begin
      a = W'(nxt);
      @(negedge clk);
      if (in_ready) nxt++;
      guard++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    n_chk++;
    if (obs_q.size() != 10) begin
      n_fail++;
      $display("FAIL bp_count: got %0d expected 10", obs_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        r = obs_q[i];
        n_chk++;
        if (r[W+1:2] !== W'(i + 1)) begin
          n_fail++;
          $display("FAIL bp_order%0d: got %h expected %h", i, r[W+1:2], W'(i + 1));
        end
      end
    end
  endtask

  task automatic test_reduce();
    res_t r0, r1, e0, e1;
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
    e0 = {8'h01, 1'b0, 1'b0};
    e1 = {8'h01, 1'b0, 1'b0};
`else
    e0 = {8'h00, 1'b1, 1'b1};
    e1 = {8'h00, 1'b1, 1'b1};
`endif
    out_ready = 1'b1;
    obs_q.delete();
    send(8'hFF, 8'h00, 3'd6);
    send(8'h07, 8'h00, 3'd7);
    drain();
    n_chk++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL reduce_count: got %0d expected 2", obs_q.size());
    end else begin
      r0 = obs_q[0];
      r1 = obs_q[1];
      n_chk++;
      if (r0 !== e0) begin n_fail++; $display("FAIL reduce_op6: got %h expected %h", r0, e0); end
      n_chk++;
      if (r1 !== e1) begin n_fail++; $display("FAIL reduce_op7: got %h expected %h", r1, e1); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    obs_q.delete();
    send(8'h11, 8'hFF, 3'd0);
    send(8'h22, 8'hFF, 3'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
    n_chk++; if (tx_count !== 16'h0000) begin n_fail++; $display("FAIL rmid_tx: got %h expected 0000", tx_count); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    n_chk++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL rmid_ghost: got %0d outputs expected 0", obs_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int sent, guard;
    rec = 1'b0;
    out_ready = 1'b1;
    a = 8'h01; b = 8'hFF; op = 3'd0;
    sent = 0; guard = 0;
    in_valid = 1'b1;
    while (sent < 65537 && guard < 70000) begin
      @(negedge clk);
      if (in_ready) sent++;
      guard++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    n_chk++;
    if (tx_count !== 16'h0001) begin n_fail++; $display("FAIL wrap_tx: got %h expected 0001", tx_count); end
    rec = 1'b1;
  endtask

  initial begin
    test_reset();
    test_bitwise();
    test_zero();
    test_backpressure();
    test_reduce();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
